// File: rtl/rvj1_pkg.sv
// rvj1_pkg: shared widths and write-back request type for the rvj1 core
package rvj1_pkg;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request at or after ptr
module rr_pick #(
  parameter int N = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // scan farthest-first so the candidate nearest ptr is assigned last and wins
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin sharing of the regfile write port among write-back sources
module rf_wb_arbiter
  import rvj1_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        hold,
  output logic                        rf_we,
  output logic [ADDR_WIDTH-1:0]       rf_waddr,
  output logic [DATA_WIDTH-1:0]       rf_wdata,
  output logic [N_REQ-1:0]            last_grant
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] ptr, idx;
  logic [N_REQ-1:0] gnt;
  logic xfer;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  rr_pick #(.N(N_REQ)) u_pick (
    .req (rst || hold ? '0 : req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx)
  );
  always_comb begin
    req_ready = gnt;
    xfer = |gnt;
    win_addr = req_addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
    win_data = req_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      last_grant <= '0;
    end else begin
      rf_we <= xfer && (win_addr != '0);
      if (xfer) begin
        ptr <= (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
        last_grant <= gnt;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req_valid = '0;
  logic [14:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic [2:0] req_ready;
  logic hold = 1'b0;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0] last_grant;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] dat [3] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002};

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .hold(hold), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with all requesters valid
    req_valid = 3'b111;
    tick();
    chk("rst_ready", 32'(req_ready), 32'b000);
    tick();
    chk("rst_ready2", 32'(req_ready), 32'b000);
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_waddr", 32'(rf_waddr), 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_lastg", 32'(last_grant), 0);
    rst = 1'b0;
    // single source 1 writes x5
    req_valid = 3'b010;
    req_addr = {5'd0, 5'd5, 5'd0};
    req_data = {32'h0, 32'hDEADBEEF, 32'h0};
    #1;
    chk("single_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = 3'b000;
    chk("single_we", 32'(rf_we), 1);
    chk("single_waddr", 32'(rf_waddr), 5);
    chk("single_wdata", rf_wdata, 32'hDEADBEEF);
    chk("single_lastg", 32'(last_grant), 32'b010);
    tick();
    chk("single_we_off", 32'(rf_we), 0);
    chk("single_waddr_hold", 32'(rf_waddr), 5);
    // x0 write from source 2 (ptr is 2 after the source-1 grant)
    req_valid = 3'b100;
    req_addr = {5'd0, 5'd0, 5'd0};
    req_data = {32'h1234, 32'h0, 32'h0};
    #1;
    chk("x0_ready", 32'(req_ready), 32'b100);
    tick();
    chk("x0_we", 32'(rf_we), 0);
    chk("x0_lastg", 32'(last_grant), 32'b100);
    chk("x0_wdata", rf_wdata, 32'h1234);
    // round robin from ptr=0 with all three valid
    req_valid = 3'b111;
    req_addr = {5'd3, 5'd2, 5'd1};
    req_data = {dat[2], dat[1], dat[0]};
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      chk("rr_we", 32'(rf_we), 1);
      chk("rr_waddr", 32'(rf_waddr), 32'(k % 3 + 1));
      chk("rr_wdata", rf_wdata, dat[k % 3]);
    end
    // hold with src0/src1 pending; src2 write from the last rr cycle is in flight
    req_valid = 3'b011;
    hold = 1'b1;
    #1;
    chk("hold_ready0", 32'(req_ready), 0);
    chk("hold_inflight_we", 32'(rf_we), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_ready", 32'(req_ready), 0);
      chk("hold_we", 32'(rf_we), 0);
    end
    hold = 1'b0;
    #1;
    chk("hold_release_ready", 32'(req_ready), 32'b001);
    tick();
    chk("hold_release_we", 32'(rf_we), 1);
    chk("hold_release_lastg", 32'(last_grant), 32'b001);
    // reset mid-stream: ptr is 1 here, reset must return it to 0
    req_valid = 3'b111;
    #1;
    chk("pre_rst_ready", 32'(req_ready), 32'b010);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 0);
    tick();
    chk("mid_rst_we", 32'(rf_we), 0);
    chk("mid_rst_lastg", 32'(last_grant), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b001);
    tick();
    chk("post_rst_waddr", 32'(rf_waddr), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
